project_controller: RTL and testbench

Sequencing FSM for the seed-scrambler datapath (seed register, shift/xor/and next-seed logic, down-counter with zero detect, output adder). On a start request it loads the seed and iteration count over the shared 16-bit data bus, then clocks the datapath once per iteration until the counter reads zero. It then captures the datapath sum output and signals completion. It sits between the system-level requester and the datapath, and owns the data-bus mux.

---
 rtl/project_controller.sv | 123 ++++++++++++
 tb/tb_project_controller.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/project_controller.sv
// Sequencer for the seed-scrambler datapath: loads seed and count over the shared bus, iterates until eq, captures z.
// Optional RUN-cycle watchdog enabled by defining PRJ_CTRL_TIMEOUT_EN.
module project_controller #(
  parameter int              WIDTH    = 16,
  parameter logic [WIDTH-1:0] MAX_ITER = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] seed_in,
  input  logic [WIDTH-1:0] count_in,
  input  logic             eq,
  input  logic [WIDTH-1:0] nseed,
  input  logic [WIDTH-1:0] z,
  output logic [WIDTH-1:0] data_out,
  output logic             lda,
  output logic             ldb,
  output logic             decb,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] result
);

  typedef enum logic [2:0] {IDLE, LD_SEED, LD_CNT, RUN, DONE} state_t;

  state_t state, state_next;
  logic   timeout;

`ifdef PRJ_CTRL_TIMEOUT_EN
  logic [WIDTH-1:0] run_cnt;
  logic             err_q;

  // run_cnt equals the number of RUN cycles already completed, so the
  // MAX_ITER-th RUN cycle without eq is the last one.
  assign timeout = (state == RUN) && !eq && (run_cnt == MAX_ITER - 1'b1);

  always_ff @(posedge clk) begin
    if (rst)
      run_cnt <= '0;
    else if (state != RUN)
      run_cnt <= '0;
    else
      run_cnt <= run_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)
      err_q <= 1'b0;
    else if (state == IDLE && start)
      err_q <= 1'b0;
    else if (timeout)
      err_q <= 1'b1;
  end

  assign err = err_q;
`else
  wire unused_max_iter = |MAX_ITER;

  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst)
      result <= '0;
    else if (state == RUN && eq)
      result <= z;
  end

  // RUN is the only state whose strobes follow eq combinationally.
  always_comb begin
    state_next = state;
    data_out   = '0;
    lda        = 1'b0;
    ldb        = 1'b0;
    decb       = 1'b0;
    case (state)
      IDLE: begin
        if (start)
          state_next = LD_SEED;
      end
      LD_SEED: begin
        data_out   = seed_in;
        lda        = 1'b1;
        state_next = LD_CNT;
      end
      LD_CNT: begin
        data_out   = count_in;
        ldb        = 1'b1;
        state_next = RUN;
      end
      RUN: begin
        if (eq) begin
          state_next = DONE;
        end else begin
          data_out = nseed;
          lda      = 1'b1;
          decb     = 1'b1;
          if (timeout)
            state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_project_controller.sv
// Self-checking bench for project_controller with a behavioural seed-scrambler datapath and a result scoreboard.
module tb_project_controller;
  localparam int WIDTH = 16;

  logic             clk   = 1'b0;
  logic             rst   = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] seed_in  = '0;
  logic [WIDTH-1:0] count_in = '0;
  logic             eq, lda, ldb, decb, busy, done, err;
  logic [WIDTH-1:0] nseed, z, data_out, result;

  logic [WIDTH-1:0] dp_seed = '0;
  logic [WIDTH-1:0] dp_cnt  = '0;

  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] exp_val;
  logic [WIDTH-1:0] last_result;
  int n_cmp = 0;
  int n_bad = 0;

  int   r_done_cyc, r_lda_n, r_ldb_n, r_decb_n, r_busy_n, r_data_bad;
  logic r_busy_pre, r_err_done, r_err_c1;
  logic [WIDTH-1:0] r_res;

  always #5 clk = ~clk;

  project_controller #(.WIDTH(WIDTH), .MAX_ITER(16'd8)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .seed_in  (seed_in),
    .count_in (count_in),
    .eq       (eq),
    .nseed    (nseed),
    .z        (z),
    .data_out (data_out),
    .lda      (lda),
    .ldb      (ldb),
    .decb     (decb),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .result   (result)
  );

  function automatic logic [WIDTH-1:0] scramble(input logic [WIDTH-1:0] s);
    return (s >> 1) ^ ((s << 3) & 16'hA000);
  endfunction

  function automatic logic [WIDTH-1:0] expected_result(input logic [WIDTH-1:0] s0, input int n);
    logic [WIDTH-1:0] s;
    s = s0;
    for (int i = 0; i < n; i++)
      s = scramble(s);
    return scramble(s) + s;
  endfunction

  // Datapath model: seed register, down-counter with zero detect, output adder.
  always @(posedge clk) begin
    if (lda) dp_seed <= data_out;
    if (ldb) dp_cnt <= data_out;
    else if (decb) dp_cnt <= dp_cnt - 1'b1;
  end
  assign eq    = (dp_cnt == '0);
  assign nseed = scramble(dp_seed);
  assign z     = nseed + dp_seed;

  // Drives one run and records what was observed; cycle k is the k-th cycle after E0.
  task automatic run_once(input logic [WIDTH-1:0] seed, input logic [WIDTH-1:0] cnt,
                          input bit hold, input int pulse_cyc);
    @(negedge clk);
    r_busy_pre = busy;
    seed_in = seed;
    count_in = cnt;
    start = 1'b1;
    r_done_cyc = -1; r_lda_n = 0; r_ldb_n = 0; r_decb_n = 0; r_busy_n = 0; r_data_bad = 0;
    r_err_done = 1'bx; r_err_c1 = 1'bx; r_res = 'x;
    @(posedge clk);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (!hold) start = (k == pulse_cyc);
      if (k == 1) r_err_c1 = err;
      if (lda)  r_lda_n++;
      if (ldb)  r_ldb_n++;
      if (decb) r_decb_n++;
      if (busy) r_busy_n++;
      if (k == 1 && data_out !== seed) r_data_bad++;
      if (k == 2 && data_out !== cnt)  r_data_bad++;
      if (decb && data_out !== nseed)  r_data_bad++;
      if (done) begin
        r_done_cyc = k;
        r_err_done = err;
        r_res = result;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({busy, done, lda, ldb, decb, err, data_out, result} !== '0) begin
        n_bad++;
        $display("[TB] FAIL reset_idle cycle %0d: busy=%b done=%b lda=%b ldb=%b decb=%b err=%b data_out=%h result=%h, required all 0",
                 i, busy, done, lda, ldb, decb, err, data_out, result);
      end
    end
    last_result = '0;
  endtask

  task automatic test_zero_iter();
    exp_q.push_back(expected_result(16'h00A5, 0));
    run_once(16'h00A5, 16'd0, 1'b0, 0);
    n_cmp++;
    if (r_done_cyc !== 4) begin n_bad++; $display("[TB] FAIL n0_done_cycle: got %0d required 4", r_done_cyc); end
    n_cmp++;
    if (r_lda_n !== 1 || r_ldb_n !== 1 || r_decb_n !== 0) begin
      n_bad++;
      $display("[TB] FAIL n0_strobes: lda=%0d ldb=%0d decb=%0d required 1/1/0", r_lda_n, r_ldb_n, r_decb_n);
    end
    n_cmp++;
    if (r_res !== 16'h00F7) begin n_bad++; $display("[TB] FAIL n0_result_const: got %h required 00f7", r_res); end
    n_cmp++;
    if (exp_q.size() == 0) begin n_bad++; $display("[TB] FAIL n0_scoreboard: got empty queue required one entry"); end
    else begin
      exp_val = exp_q.pop_front();
      if (r_res !== exp_val) begin n_bad++; $display("[TB] FAIL n0_result: got %h required %h", r_res, exp_val); end
      last_result = exp_val;
    end
  endtask

  task automatic test_three_iter();
    exp_q.push_back(expected_result(16'h1234, 3));
    run_once(16'h1234, 16'd3, 1'b0, 0);
    n_cmp++;
    if (r_done_cyc !== 7) begin n_bad++; $display("[TB] FAIL n3_done_cycle: got %0d required 7", r_done_cyc); end
    n_cmp++;
    if (r_lda_n !== 4 || r_ldb_n !== 1 || r_decb_n !== 3) begin
      n_bad++;
      $display("[TB] FAIL n3_strobes: lda=%0d ldb=%0d decb=%0d required 4/1/3", r_lda_n, r_ldb_n, r_decb_n);
    end
    n_cmp++;
    if (r_busy_n !== 7) begin n_bad++; $display("[TB] FAIL n3_busy_cycles: got %0d required 7", r_busy_n); end
    n_cmp++;
    if (r_data_bad !== 0) begin n_bad++; $display("[TB] FAIL n3_data_out: got %0d bad cycles required 0", r_data_bad); end
    n_cmp++;
    if (exp_q.size() == 0) begin n_bad++; $display("[TB] FAIL n3_scoreboard: got empty queue required one entry"); end
    else begin
      exp_val = exp_q.pop_front();
      if (r_res !== exp_val) begin n_bad++; $display("[TB] FAIL n3_result: got %h required %h", r_res, exp_val); end
      last_result = exp_val;
    end
  endtask

  task automatic test_back_to_back();
    exp_q.push_back(expected_result(16'hBEEF, 2));
    run_once(16'hBEEF, 16'd2, 1'b1, 0);
    n_cmp++;
    if (r_done_cyc !== 6) begin n_bad++; $display("[TB] FAIL b2b_first_done: got %0d required 6", r_done_cyc); end
    n_cmp++;
    if (exp_q.size() == 0) begin n_bad++; $display("[TB] FAIL b2b_first_scoreboard: got empty queue required one entry"); end
    else begin
      exp_val = exp_q.pop_front();
      if (r_res !== exp_val) begin n_bad++; $display("[TB] FAIL b2b_first_result: got %h required %h", r_res, exp_val); end
    end
    exp_q.push_back(expected_result(16'h1357, 2));
    run_once(16'h1357, 16'd2, 1'b1, 0);
    n_cmp++;
    if (r_busy_pre !== 1'b0) begin n_bad++; $display("[TB] FAIL b2b_idle_gap: busy=%b required 0", r_busy_pre); end
    n_cmp++;
    if (r_done_cyc !== 6 || r_data_bad !== 0) begin
      n_bad++;
      $display("[TB] FAIL b2b_second_run: done cycle %0d bad data %0d required 6/0", r_done_cyc, r_data_bad);
    end
    n_cmp++;
    if (exp_q.size() == 0) begin n_bad++; $display("[TB] FAIL b2b_second_scoreboard: got empty queue required one entry"); end
    else begin
      exp_val = exp_q.pop_front();
      if (r_res !== exp_val) begin n_bad++; $display("[TB] FAIL b2b_second_result: got %h required %h", r_res, exp_val); end
      last_result = exp_val;
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_start_ignored();
    int busy_after;
    exp_q.push_back(expected_result(16'h2468, 2));
    run_once(16'h2468, 16'd2, 1'b0, 3);
    n_cmp++;
    if (r_done_cyc !== 6 || r_lda_n !== 3) begin
      n_bad++;
      $display("[TB] FAIL ignore_run: done cycle %0d lda %0d required 6/3", r_done_cyc, r_lda_n);
    end
    n_cmp++;
    if (exp_q.size() == 0) begin n_bad++; $display("[TB] FAIL ignore_scoreboard: got empty queue required one entry"); end
    else begin
      exp_val = exp_q.pop_front();
      if (r_res !== exp_val) begin n_bad++; $display("[TB] FAIL ignore_result: got %h required %h", r_res, exp_val); end
      last_result = exp_val;
    end
    busy_after = 0;
    repeat (4) begin
      @(negedge clk);
      if (busy) busy_after++;
    end
    n_cmp++;
    if (busy_after !== 0) begin n_bad++; $display("[TB] FAIL ignore_no_restart: busy %0d cycles required 0", busy_after); end
  endtask

  task automatic test_mid_run_reset();
    int done_seen;
    @(negedge clk);
    seed_in = 16'h7777;
    count_in = 16'd5;
    start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == 4) begin
        n_cmp++;
        if (decb !== 1'b1) begin n_bad++; $display("[TB] FAIL rst_in_run: decb=%b required 1", decb); end
        rst = 1'b1;
      end
    end
    @(negedge clk);
    n_cmp++;
    if ({busy, done, lda, ldb, decb, data_out, result} !== '0) begin
      n_bad++;
      $display("[TB] FAIL rst_abort: busy=%b done=%b lda=%b ldb=%b decb=%b data_out=%h result=%h required all 0 (prior result %h)",
               busy, done, lda, ldb, decb, data_out, result, last_result);
    end
    rst = 1'b0;
    last_result = '0;
    done_seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    n_cmp++;
    if (done_seen !== 0) begin n_bad++; $display("[TB] FAIL rst_no_done: done %0d cycles required 0", done_seen); end
  endtask

  task automatic test_timeout();
    int exp_done;
    logic exp_err;
    exp_q.push_back(expected_result(16'h5A3C, 1));
    run_once(16'h5A3C, 16'd1, 1'b0, 0);
    n_cmp++;
    if (exp_q.size() == 0) begin n_bad++; $display("[TB] FAIL to_pre_scoreboard: got empty queue required one entry"); end
    else begin
      exp_val = exp_q.pop_front();
      if (r_res !== exp_val || r_done_cyc !== 5) begin
        n_bad++;
        $display("[TB] FAIL to_pre_run: result %h done cycle %0d required %h/5", r_res, r_done_cyc, exp_val);
      end
      last_result = exp_val;
    end
`ifdef PRJ_CTRL_TIMEOUT_EN
    exp_done = 11;
    exp_err  = 1'b1;
    exp_q.push_back(last_result);
`else
    exp_done = 14;
    exp_err  = 1'b0;
    exp_q.push_back(expected_result(16'hC3F1, 10));
`endif
    run_once(16'hC3F1, 16'd10, 1'b0, 0);
    n_cmp++;
    if (r_done_cyc !== exp_done) begin n_bad++; $display("[TB] FAIL to_done_cycle: got %0d required %0d", r_done_cyc, exp_done); end
    n_cmp++;
    if (r_err_done !== exp_err) begin n_bad++; $display("[TB] FAIL to_err: got %b required %b", r_err_done, exp_err); end
    n_cmp++;
    if (exp_q.size() == 0) begin n_bad++; $display("[TB] FAIL to_scoreboard: got empty queue required one entry"); end
    else begin
      exp_val = exp_q.pop_front();
      if (r_res !== exp_val) begin n_bad++; $display("[TB] FAIL to_result: got %h required %h", r_res, exp_val); end
      last_result = exp_val;
    end
    repeat (2) @(negedge clk);
    n_cmp++;
    if (err !== exp_err) begin n_bad++; $display("[TB] FAIL to_err_hold: got %b required %b", err, exp_err); end
    exp_q.push_back(expected_result(16'h0F0F, 0));
    run_once(16'h0F0F, 16'd0, 1'b0, 0);
    n_cmp++;
    if (r_err_c1 !== 1'b0 || r_err_done !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL to_err_clear: cycle1 err=%b done err=%b required 0/0", r_err_c1, r_err_done);
    end
    n_cmp++;
    if (exp_q.size() == 0) begin n_bad++; $display("[TB] FAIL to_post_scoreboard: got empty queue required one entry"); end
    else begin
      exp_val = exp_q.pop_front();
      if (r_res !== exp_val || r_done_cyc !== 4) begin
        n_bad++;
        $display("[TB] FAIL to_post_run: result %h done cycle %0d required %h/4", r_res, r_done_cyc, exp_val);
      end
    end
  endtask

  initial begin
    $display("[TB] starting project_controller bench");
    test_reset();
    test_zero_iter();
    test_three_iter();
    test_back_to_back();
    test_start_ignored();
    test_mid_run_reset();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish, required completion before 200000");
    $fatal(1, "[TB] timeout");
  end

endmodule
